// File: rtl/pc_stack.sv
// Program counter with segment load, relative branch/call and an optional return stack.
// Return stack is compiled in only when PC_STACK_RET_EN is defined.
module pc_stack #(
    parameter  int ADDR_W      = 8,
    parameter  int BUS_W       = 4,
    parameter  int STACK_DEPTH = 4,
    localparam int NSEG        = ADDR_W / BUS_W,
    localparam int SEL_W       = $clog2(NSEG)
) (
    input  logic              clock,
    input  logic              reset,
    input  logic [BUS_W-1:0]  parallel_input,
    input  logic [SEL_W-1:0]  seg_sel,
    input  logic              load_en,
    input  logic              CYin,
    input  logic              CYin_control,
    input  logic              br_en,
    input  logic              call_en,
    input  logic              ret_en,
    input  logic [ADDR_W-1:0] br_off,
    input  logic              count_en,
    output logic [ADDR_W-1:0] Q,
    output logic              stack_empty,
    output logic              stack_full,
    output logic              stack_err
);

    logic [ADDR_W-1:0] r_q;
    logic [ADDR_W-1:0] w_load;
    logic [ADDR_W-1:0] w_rel;
    logic [ADDR_W-1:0] w_inc;
    int                w_sh;

    assign w_rel = r_q + br_off;
    assign w_inc = r_q + ADDR_W'(1);

    // Carry is added at the first bit above the loaded segment, so it can
    // only ripple upward; the segment itself is then overwritten.
    always_comb begin
        w_load = r_q;
        w_sh   = (int'(seg_sel) + 1) * BUS_W;
        if (CYin_control && CYin && (seg_sel < SEL_W'(NSEG - 1)))
            w_load = r_q + (ADDR_W'(1) << w_sh);
        for (int s = 0; s < NSEG; s++)
            if (seg_sel == SEL_W'(s))
                w_load[s*BUS_W +: BUS_W] = parallel_input;
    end

    assign Q = r_q;

`ifdef PC_STACK_RET_EN
    localparam int CNT_W = $clog2(STACK_DEPTH + 1);
    localparam int IDX_W = $clog2(STACK_DEPTH);
    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(STACK_DEPTH);

    logic [ADDR_W-1:0] r_stk [STACK_DEPTH];
    logic [CNT_W-1:0]  r_cnt;
    logic              r_empty;
    logic              r_full;
    logic              r_err;
    logic [IDX_W-1:0]  w_push_idx;
    logic [IDX_W-1:0]  w_pop_idx;

    assign w_push_idx = IDX_W'(r_cnt);
    assign w_pop_idx  = IDX_W'(r_cnt - CNT_W'(1));

    // Storage is not cleared on reset; occupancy gating keeps stale entries unreachable.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_q     <= '0;
            r_cnt   <= '0;
            r_empty <= 1'b1;
            r_full  <= 1'b0;
            r_err   <= 1'b0;
        end else begin
            r_err <= 1'b0;
            if (load_en) begin
                r_q <= w_load;
            end else if (br_en) begin
                r_q <= w_rel;
            end else if (call_en) begin
                if (r_cnt == DEPTH_C) begin
                    r_err <= 1'b1;
                end else begin
                    r_stk[w_push_idx] <= w_inc;
                    r_q               <= w_rel;
                    r_cnt             <= r_cnt + CNT_W'(1);
                    r_empty           <= 1'b0;
                    r_full            <= (r_cnt == DEPTH_C - CNT_W'(1));
                end
            end else if (ret_en) begin
                if (r_cnt == '0) begin
                    r_err <= 1'b1;
                end else begin
                    r_q     <= r_stk[w_pop_idx];
                    r_cnt   <= r_cnt - CNT_W'(1);
                    r_full  <= 1'b0;
                    r_empty <= (r_cnt == CNT_W'(1));
                end
            end else if (count_en) begin
                r_q <= w_inc;
            end
        end
    end

    assign stack_empty = r_empty;
    assign stack_full  = r_full;
    assign stack_err   = r_err;
`else
    logic w_unused_ret;
    assign w_unused_ret = ret_en;

    // Without a stack, call degenerates to a branch and ret is not an action.
    always_ff @(posedge clock) begin
        if (reset)
            r_q <= '0;
        else if (load_en)
            r_q <= w_load;
        else if (br_en || call_en)
            r_q <= w_rel;
        else if (count_en)
            r_q <= w_inc;
    end

    assign stack_empty = 1'b1;
    assign stack_full  = 1'b0;
    assign stack_err   = 1'b0;
`endif

endmodule

// File: doc/pc_stack.md
PC_STACK -- requirements
Module: pc_stack

Interface
REQ-001 Parameters SHALL be: ADDR_W, default 8, counter width; BUS_W, default 4, segment load width (ADDR_W SHALL be an integer multiple of BUS_W, at least 2 segments); STACK_DEPTH, default 4, return-stack entries (at least 2).
REQ-002 Ports SHALL be: clock  in  1  single clock, rising edge.
REQ-003 reset  in  1  synchronous, active-high; overrides all other inputs.
REQ-004 parallel_input  in  BUS_W  segment load data.
REQ-005 seg_sel  in  clog2(ADDR_W/BUS_W)  segment index for load_en; 0 = least significant segment.
REQ-006 load_en  in  1  load parallel_input into segment seg_sel.
REQ-007 CYin  in  1  carry into the bits above the loaded segment.
REQ-008 CYin_control  in  1  enables the CYin addition during load_en.
REQ-009 br_en  in  1  relative branch.
REQ-010 call_en  in  1  relative call (push return address).
REQ-011 ret_en  in  1  return (pop).
REQ-012 br_off  in  ADDR_W  two's-complement offset for br_en and call_en.
REQ-013 count_en  in  1  increment enable.
REQ-014 Q  out  ADDR_W  program counter, registered.
REQ-015 stack_empty  out  1 and stack_full  out  1  registered stack status.
REQ-016 stack_err  out  1  registered single-cycle pulse on overflow or underflow.

Function
REQ-017 Exactly one action SHALL occur per rising edge, with priority reset > load_en > br_en > call_en > ret_en > count_en > hold.
REQ-018 load_en SHALL write parallel_input to Q[seg_sel*BUS_W +: BUS_W] and leave lower bits unchanged; when CYin_control=1, bits above the segment SHALL become their old value plus CYin, mod 2^width (no wrap into the loaded segment); otherwise they SHALL be unchanged.
REQ-019 A load to the top segment SHALL ignore CYin.
REQ-020 br_en SHALL set Q to Q+br_off mod 2^ADDR_W.
REQ-021 call_en with the stack not full SHALL push Q+1 mod 2^ADDR_W and set Q to Q+br_off mod 2^ADDR_W, both in the same cycle.
REQ-022 call_en with the stack full SHALL leave Q and the stack unchanged and pulse stack_err for one cycle.
REQ-023 ret_en with the stack not empty SHALL set Q to the top entry and pop it in the same cycle.
REQ-024 ret_en with the stack empty SHALL leave Q unchanged and pulse stack_err.
REQ-025 count_en SHALL increment Q by 1; all-ones SHALL wrap to 0 with no flag.
REQ-026 The stack SHALL be LIFO, and its occupancy SHALL change only on a successful call or return.
REQ-027 stack_full SHALL be 1 exactly when occupancy = STACK_DEPTH, and stack_empty SHALL be 1 exactly when occupancy = 0; both SHALL reflect the post-edge occupancy.
REQ-028 A lower-priority request asserted together with a higher-priority one SHALL be discarded, not deferred.
REQ-029 Every output SHALL change only on a rising clock edge, and each action SHALL be visible on Q one cycle after the edge that samples it.

Reset
REQ-030 On a reset edge: Q=0, occupancy=0, stack_empty=1, stack_full=0, stack_err=0.
REQ-031 Reset mid-sequence SHALL discard all stack contents; a following ret_en SHALL underflow.
REQ-032 Stack storage contents need not be cleared, but SHALL never be observable after reset.

Configuration
REQ-033 Macro PC_STACK_RET_EN defined: the return stack SHALL be compiled in and behave per REQ-021 to REQ-027.
REQ-034 Macro PC_STACK_RET_EN undefined: there SHALL be no stack storage; call_en SHALL act as br_en; ret_en SHALL be ignored; stack_empty SHALL be tied 1, and stack_full and stack_err SHALL be tied 0.
REQ-035 The port list SHALL be identical in both builds.

Verification (defaults ADDR_W=8, BUS_W=4, STACK_DEPTH=4, macro defined unless noted)
REQ-036 Reset, then count_en=1 for 3 cycles -> Q=0x03; preload Q=0xFF, count -> Q=0x00.
REQ-037 Q=0x2F, load_en, seg_sel=0, parallel_input=0x3, CYin=1, CYin_control=1 -> Q=0x33; same stimulus with CYin_control=0 -> Q=0x23.
REQ-038 Q=0x10, br_en, br_off=0xFC -> Q=0x0C; with load_en also asserted (seg_sel=1, data=0xA) -> Q=0xA0.
REQ-039 From Q=0x00, four calls with br_off=0x10 -> Q=0x40 and stack_full=1; fifth call -> Q=0x40 and stack_err pulses once; four returns -> Q=0x31, 0x21, 0x11, 0x01, then stack_empty=1.
REQ-040 ret_en on an empty stack -> Q unchanged and stack_err=1 for one cycle; reset after two calls, then ret_en -> underflow.
REQ-041 Macro undefined: Q=0x05, call_en, br_off=0x03 -> Q=0x08; ret_en -> Q=0x08, stack_err=0, stack_empty=1.
